// File: rtl/dsdemod3.sv
// Third-order CIC decimator: turns a 1-bit delta-sigma stream into signed n-bit
// samples at 1/2^r of the bit rate, with a one-cycle valid strobe per sample.
module dsdemod3 #(
    parameter int n = 16,
    parameter int r = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in,
    output logic [n-1:0] out,
    output logic         valid
);

    localparam int B  = 3 * r + 2;
    localparam int SH = 3 * r + 1 - n;

    generate
        if (3 * r + 1 < n) begin : g_bad_params
            $error("dsdemod3: parameters must satisfy 3r+1 >= n");
        end
    endgenerate

    // +2^(n-1) after scaling is the single value that does not fit in n bits
    localparam logic [B-1:0] POS_FS = {{(B - n){1'b0}}, 1'b1, {(n - 1){1'b0}}};

    logic signed [B-1:0] i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
    logic signed [B-1:0] d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
    logic        [r-1:0] cnt_q, cnt_d;
    logic        [n-1:0] out_q, out_d;
    logic                valid_q, valid_d;

    logic signed [B-1:0] x, c1, c2, c3, s;
    logic                tick;

    always_comb begin
        x     = in ? B'(1) : '1;
        i1_d  = i1_q + x;
        i2_d  = i2_q + i1_q;
        i3_d  = i3_q + i2_q;
        cnt_d = cnt_q + 1'b1;
        tick  = (cnt_q == '1);

        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;
        s  = c3 >>> SH;

        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (tick) begin
            d1_d    = i3_q;
            d2_d    = c1;
            d3_d    = c2;
            out_d   = (s == POS_FS) ? {1'b0, {(n - 1){1'b1}}} : s[n-1:0];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            i3_q    <= i3_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_dsdemod3.sv
// Bench for dsdemod3: periodic bit patterns (directed and random) checked against
// the steady-state CIC output R^3 * mean(x), plus strobe timing and reset behaviour.
module tb_dsdemod3;

    localparam int N  = 16;
    localparam int RL = 6;
    localparam int R  = 1 << RL;
    localparam int SH = 3 * RL + 1 - N;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         in_b = 1'b0;
    logic [N-1:0] out;
    logic         valid;

    int checks   = 0;
    int failures = 0;
    int e        = 0;   // edges with clr=0 since the last reset
    int vcount   = 0;   // valid strobes since the last reset

    dsdemod3 #(.n(N), .r(RL)) dut (
        .clk  (clk),
        .clr  (clr),
        .in   (in_b),
        .out  (out),
        .valid(valid)
    );

    always #5 clk = ~clk;

    // Steady-state output for a pattern whose period P divides R:
    // each boxcar stage turns it into R*mean, so y = R^3 * sum(pattern) / P.
    function automatic logic [N-1:0] model(input logic [63:0] p, input int P);
        longint sum = 0;
        longint y, v;
        for (int i = 0; i < P; i++) sum += p[i] ? 1 : -1;
        y = sum * longint'(R / P) * R * R;
        v = y >>> SH;
        if (v == (longint'(1) << (N - 1))) v = v - 1;
        return v[N-1:0];
    endfunction

    task automatic step(input logic b, input logic c);
        in_b = b;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_valid(input string tag, input logic exp_v);
        checks++;
        assert (valid === exp_v) else begin
            failures++;
            $error("FAIL %s e=%0d valid observed=%0b expected=%0b", tag, e, valid, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] exp_o);
        checks++;
        assert (out === exp_o) else begin
            failures++;
            $error("FAIL %s e=%0d out observed=%0d expected=%0d",
                   tag, e, $signed(out), $signed(exp_o));
        end
    endtask

    task automatic do_reset(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'($urandom), 1'b1);
            chk_valid("reset_valid", 1'b0);
            chk_out("reset_out", '0);
        end
        e      = 0;
        vcount = 0;
    endtask

    task automatic run(input string tag, input logic [63:0] p, input int P, input int ncyc);
        logic [N-1:0] exp_o;
        logic         exp_v;
        exp_o = model(p, P);
        for (int k = 0; k < ncyc; k++) begin
            step(p[e % P], 1'b0);
            e++;
            exp_v = (e % R == 0);
            chk_valid({tag, "_valid"}, exp_v);
            if (exp_v) vcount++;
            if (vcount >= 4) chk_out({tag, "_out"}, exp_o);
        end
    endtask

    initial begin
        logic [63:0] pat;
        int          P;

        do_reset(2);

        run("ones", 64'h1, 1, 400);
        do_reset(1);
        run("zeros", 64'h0, 1, 400);
        do_reset(1);
        run("alt", 64'h1, 2, 400);
        do_reset(1);
        run("d75", 64'h7, 4, 400);

        // one-cycle clear in the middle of an all-ones stream
        do_reset(1);
        run("ones_pre", 64'h1, 1, 100);
        do_reset(1);
        run("ones_post", 64'h1, 1, 300);

        // held clear whose first edge coincides with a decimation tick
        do_reset(1);
        run("ones_tick", 64'h1, 1, R - 1);
        do_reset(10);
        run("ones_after_hold", 64'h1, 1, 5 * R);

        for (int t = 0; t < 6; t++) begin
            P   = 1 << $urandom_range(0, RL);
            pat = {$urandom, $urandom};
            do_reset(1);
            run("rand", pat, P, 6 * R);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsdemod3.md
# dsdemod3

Third-order CIC decimating demodulator: converts a 1-bit delta-sigma stream (as produced by the team's first-order modulator) back into signed n-bit integers at 1/R of the bit rate. The block sits on the receive side of a bitstream link or at a 1-bit ADC front end, and feeds a decimated PCM sample stream with a one-cycle valid strobe to downstream filtering or logic. It is fully synchronous, with no handshake back-pressure. Samples are produced at a fixed rate.

## Interface
Parameters:
- n, 16: output sample width, signed two's complement.
- r, 6: log2 of decimation ratio; R = 2^r. Constraint 3r+1 >= n (elaboration error otherwise).

Ports:
- clk  in  1  bit-rate clock; one input bit consumed per rising edge.
- clr  in  1  reset; synchronous, active-high.
- in  in  1  bitstream input; 1 maps to +1, 0 maps to -1.
- out  out  n  signed decoded sample; held between strobes.
- valid  out  1  one-cycle strobe; out is new in this cycle.

## Operation
- Internal width B = 3r+2. All integrator/comb registers are B-bit signed and wrap modulo 2^B. No saturation inside the chain.
- Input map x = in ? +1 : -1, sign-extended to B bits.
- Integrators are registered, and each uses the old values of the other registers at every clk edge: i1 <= i1 + x; i2 <= i2 + i1; i3 <= i3 + i2.
- Decimation counter cnt (r bits) increments every edge and wraps R-1 -> 0. The tick condition is cnt == R-1.
- On a tick edge only, the comb stages update:
  - c1 = i3 - d1, d1 <= i3.
  - c2 = c1 - d2, d2 <= c1.
  - c3 = c2 - d3, d3 <= c2.
  - c1..c3 are combinational within the tick cycle.
- Output scaling, on a tick edge:
  - y = c3, whose range is [-2^(3r), +2^(3r)].
  - s = y >>> (3r+1-n), an arithmetic shift.
  - If s = +2^(n-1), s saturates to 2^(n-1)-1. This is the only overflow case.
  - out <= s; valid <= 1.
- On non-tick edges: valid <= 0, out holds, and the comb registers hold.
- Reset, on a clk edge with clr=1:
  - i1..i3, d1..d3, cnt, out and valid are all cleared to 0.
  - The in bit of that edge is discarded.
  - Reset takes priority over a coincident tick.
- Reset mid-operation discards all partial accumulation. There is no output from the interrupted decimation period.

## Timing
- Reset values: out = 0, valid = 0, cnt = 0, all accumulators = 0.
- valid is high for exactly one cycle every R cycles. There are never two consecutive valid cycles.
- First valid: high in the cycle after the R-th clk edge with clr=0. The first R bits after reset release are then integrated.
- Period: each following valid comes R edges after the previous one. out changes only on the same edge that raises valid.
- Settling:
  - The first three valid samples after reset are transient; no value is required of them.
  - From the 4th valid onward, out is exact for any input whose pattern is periodic with a period dividing R.
- Latency for a step in bit density: full effect by the 3rd valid after the step. The filter impulse response spans 3R-2 input bits.
- in has no qualifier; every edge with clr=0 consumes a bit.

## Test plan
- All-ones, r=6, n=16 for 400 cycles: valid pulses exactly every 64 cycles; out = 32767 (saturated +2^15) from the 4th valid on.
- All-zeros: out = -32768 from the 4th valid on; no wrap artefacts.
- Alternating 1,0,1,0...: out = 0 exactly from the 4th valid on.
- Repeating 1,1,1,0 (density 0.75): y = 2^17, out = 16384 from the 4th valid on.
- clr high for one cycle at cycle 100 during the all-ones stream:
  - next edge: out = 0, valid = 0;
  - next valid exactly 64 edges after the clr edge;
  - out is 32767 again from the 4th valid after the clr edge.
- clr held high for 10 cycles, with the tick coincident: no valid during clr, and out stays 0.
